// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
//  Module      : weight_loader
//  Description : Byte-serial weight programmer. Parses HEADER/ADDR/LEN/DATA/CHK
//                frames, stages the payload with a per-byte write mask, checks
//                an XOR checksum and commits all staged bytes to the active
//                weight bank in a single edge while the network is idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module weight_loader #(
  parameter int                       NUM_WEIGHTS  = 10,
  parameter logic [8*NUM_WEIGHTS-1:0] INIT_WEIGHTS = '0,
  parameter logic [7:0]               HEADER       = 8'hA5,
  parameter int                       TIMEOUT      = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [7:0]               data_i,
  input  logic                     strobe_i,
  input  logic                     net_busy_i,
  output logic [8*NUM_WEIGHTS-1:0] weights_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  // Idle counter must be able to hold the value TIMEOUT itself.
  localparam int             TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W:0] TMO_LIMIT = (TMO_W + 1)'(TIMEOUT);
  // Bank size in the 9-bit domain used for the ADDR+LEN range check.
  localparam logic [8:0]     BANK_SIZE = 9'(NUM_WEIGHTS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_LEN    = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHK    = 3'd4;
  localparam logic [2:0] S_COMMIT = 3'd5;

  logic [2:0]       state;
  logic [2:0]       state_nxt;

  logic [7:0]       addr;
  logic [7:0]       len;
  logic [7:0]       cnt;
  logic [7:0]       chk_acc;
  logic [TMO_W-1:0] idle_cnt;

  // Frame-level decodes.
  logic             in_frame;
  logic             len_bad;
  logic             last_byte;
  logic             chk_ok;
  logic             timed_out;
  logic [TMO_W:0]   idle_inc;
  logic [8:0]       wr_idx;

  // Events produced by the output decode.
  logic             data_we;
  logic             commit_go;
  logic             reject;
  logic             mask_clr;

  logic             done_q;
  logic             err_q;
  logic             busy_q;

  // ------------------------------------------------------------------------
  // Frame decodes shared by the FSM and the datapath
  // ------------------------------------------------------------------------
  assign in_frame  = (state == S_ADDR) || (state == S_LEN) ||
                     (state == S_DATA) || (state == S_CHK);
  // LEN of zero or a run past the end of the bank; 9 bits so ADDR+LEN never wraps.
  assign len_bad   = (data_i == 8'd0) ||
                     (({1'b0, addr} + {1'b0, data_i}) > BANK_SIZE);
  assign last_byte = (cnt == (len - 8'd1));
  assign chk_ok    = (data_i == chk_acc);
  assign idle_inc  = {1'b0, idle_cnt} + {{TMO_W{1'b0}}, 1'b1};
  // The idle cycle that brings the count up to TIMEOUT aborts the frame.
  assign timed_out = in_frame && !strobe_i && (idle_inc >= TMO_LIMIT);
  assign wr_idx    = {1'b0, addr} + {1'b0, cnt};

  // ------------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------------
  // Hold the current frame-parsing state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ------------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------------
  // Advance one field per strobed byte; a timeout always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (strobe_i && (data_i == HEADER)) begin
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (strobe_i) begin
          state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        if (strobe_i) begin
          state_nxt = len_bad ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (strobe_i && last_byte) begin
          state_nxt = S_CHK;
        end
      end
      S_CHK: begin
        if (strobe_i) begin
          state_nxt = chk_ok ? S_COMMIT : S_IDLE;
        end
      end
      S_COMMIT: begin
        // Bytes arriving here are dropped; the host is expected to watch busy_o.
        if (!net_busy_i) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (timed_out) begin
      state_nxt = S_IDLE;
    end
  end

  // ------------------------------------------------------------------------
  // FSM: output decode
  // ------------------------------------------------------------------------
  // Derive staging writes, commit and reject events from state and input byte.
  always_comb begin
    data_we   = 1'b0;
    commit_go = 1'b0;
    reject    = 1'b0;
    case (state)
      S_LEN: begin
        reject = strobe_i && len_bad;
      end
      S_DATA: begin
        data_we = strobe_i;
      end
      S_CHK: begin
        reject = strobe_i && !chk_ok;
      end
      S_COMMIT: begin
        commit_go = !net_busy_i;
      end
      default: begin
        data_we = 1'b0;
      end
    endcase
    if (timed_out) begin
      reject = 1'b1;
    end
    mask_clr = commit_go || reject;
  end

  // ------------------------------------------------------------------------
  // Status outputs
  // ------------------------------------------------------------------------
  // Register the one-cycle pulses and the busy flag so the outputs are glitch-free.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      done_q <= commit_go;
      err_q  <= reject;
      busy_q <= (state_nxt != S_IDLE);
    end
  end

  assign done_o = done_q;
  assign err_o  = err_q;
  assign busy_o = busy_q;

  // ------------------------------------------------------------------------
  // Frame field capture, checksum accumulation and idle timer
  // ------------------------------------------------------------------------
  // Latch ADDR/LEN, step the data index and fold every field into the checksum.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr    <= 8'd0;
      len     <= 8'd0;
      cnt     <= 8'd0;
      chk_acc <= 8'd0;
    end else if (strobe_i) begin
      case (state)
        S_ADDR: begin
          addr    <= data_i;
          chk_acc <= data_i;
        end
        S_LEN: begin
          len     <= data_i;
          cnt     <= 8'd0;
          chk_acc <= chk_acc ^ data_i;
        end
        S_DATA: begin
          cnt     <= cnt + 8'd1;
          chk_acc <= chk_acc ^ data_i;
        end
        default: begin
          chk_acc <= chk_acc;
        end
      endcase
    end
  end

  // Count consecutive byte-less cycles inside a frame; saturate at TIMEOUT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_cnt <= '0;
    end else if (!in_frame || strobe_i) begin
      idle_cnt <= '0;
    end else if (idle_inc <= TMO_LIMIT) begin
      idle_cnt <= idle_inc[TMO_W-1:0];
    end
  end

  // ------------------------------------------------------------------------
  // Per-slot staging byte, write-mask bit and active bank byte
  // ------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_WEIGHTS; i++) begin : g_slot
    logic       hit;
    logic [7:0] stage_q;
    logic       mask_q;
    logic [7:0] bank_q;

    assign hit = data_we && (wr_idx == 9'(i));

    // Stage the payload byte for this slot and remember that it was written.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        stage_q <= 8'd0;
        mask_q  <= 1'b0;
      end else begin
        if (hit) begin
          stage_q <= data_i;
        end
        if (mask_clr) begin
          mask_q <= 1'b0;
        end else if (hit) begin
          mask_q <= 1'b1;
        end
      end
    end

    // Active bank byte: all masked slots update together on the commit edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        bank_q <= INIT_WEIGHTS[8*i +: 8];
      end else if (commit_go && mask_q) begin
        bank_q <= stage_q;
      end
    end

    assign weights_o[8*i +: 8] = bank_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_weight_loader
//  Description : Randomised self-checking bench for weight_loader. Stimulus
//                pushes each expected done/err event (with the bank contents
//                that must be visible then) into a queue; a monitor pops and
//                compares whenever the DUT raises done_o or err_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_loader;

  localparam int              NW   = 10;
  localparam logic [8*NW-1:0] INIT = 80'h1357_9BDF_2468_ACE0_1122;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [7:0]      data_i;
  logic            strobe_i;
  logic            net_busy_i;
  logic [8*NW-1:0] weights_o;
  logic            busy_o;
  logic            done_o;
  logic            err_o;

  weight_loader #(
    .NUM_WEIGHTS (NW),
    .INIT_WEIGHTS(INIT),
    .HEADER      (8'hA5),
    .TIMEOUT     (255)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .data_i    (data_i),
    .strobe_i  (strobe_i),
    .net_busy_i(net_busy_i),
    .weights_o (weights_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              is_done;
    logic [8*NW-1:0] w;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model[NW];
  logic [7:0] pay[16];
  int         errors    = 0;
  int         checks    = 0;
  int         err_seen  = 0;
  int         done_seen = 0;

  function automatic void check(string name, logic [79:0] act, logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [8*NW-1:0] model_vec();
    logic [8*NW-1:0] v;
    for (int i = 0; i < NW; i++) v[8*i +: 8] = model[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NW; i++) model[i] = INIT[8*i +: 8];
  endfunction

  // Monitor: every done/err pulse must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_i && (done_o || err_o)) begin
      if (done_o) done_seen++;
      if (err_o) err_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: done=%0b err=%0b with nothing expected", done_o, err_o);
      end else begin
        e = sb.pop_front();
        check("event_kind_done", 80'(done_o), 80'(e.is_done));
        check("event_kind_err", 80'(err_o), 80'(!e.is_done));
        check("event_weights", weights_o, e.w);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    data_i   = b;
    strobe_i = 1'b1;
    @(posedge clk);
    #1;
    strobe_i = 1'b0;
    data_i   = 8'($urandom);
  endtask

  task automatic gap(input bit gaps);
    if (gaps) tick(int'($urandom_range(0, 3)));
  endtask

  // Send one frame using pay[] as payload; chk_flip corrupts the checksum.
  task automatic frame(input logic [7:0] a, input logic [7:0] l, input logic [7:0] chk_flip,
                       input int hold, input bit gaps);
    logic [7:0]      x;
    logic [8*NW-1:0] prev;
    exp_t            e;
    int              lat;
    send(8'hA5);
    gap(gaps);
    send(a);
    check("busy_in_frame", 80'(busy_o), 80'(1));
    gap(gaps);
    if (l == 0 || int'(a) + int'(l) > NW) begin
      e.is_done = 1'b0;
      e.w       = model_vec();
      sb.push_back(e);
      send(l);
      tick(2);
      return;
    end
    x = a ^ l;
    send(l);
    for (int k = 0; k < int'(l); k++) begin
      gap(gaps);
      x = x ^ pay[k];
      send(pay[k]);
    end
    x    = x ^ chk_flip;
    prev = model_vec();
    if (chk_flip == 8'd0) begin
      for (int k = 0; k < int'(l); k++) model[int'(a) + k] = pay[k];
      e.is_done = 1'b1;
    end else begin
      e.is_done = 1'b0;
    end
    e.w = model_vec();
    sb.push_back(e);
    gap(gaps);
    if (hold > 0 && chk_flip == 8'd0) begin
      net_busy_i = 1'b1;
      send(x);
      for (int h = 0; h < hold; h++) begin
        tick(1);
        check("hold_frozen", weights_o, prev);
        check("hold_busy", 80'(busy_o), 80'(1));
      end
      net_busy_i = 1'b0;
      lat = 1;
      while (lat <= 4) begin
        @(negedge clk);
        if (done_o) break;
        lat++;
      end
      check("commit_latency_ok", 80'(lat <= 2), 80'(1));
      tick(3);
    end else begin
      send(x);
      tick(3);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst_i      = 1'b1;
    strobe_i   = 1'b0;
    net_busy_i = 1'b0;
    data_i     = 8'h00;
    model_reset();
    #2;
    check("reset_weights", weights_o, INIT);
    check("reset_busy", 80'(busy_o), 80'(0));
    check("reset_done", 80'(done_o), 80'(0));
    check("reset_err", 80'(err_o), 80'(0));
    tick(2);
    rst_i = 1'b0;
    tick(2);

    // Single-byte frame to slot 2.
    pay[0] = 8'h7C;
    frame(8'h02, 8'h01, 8'h00, 0, 1'b0);
    check("t1_byte2", 80'(weights_o[23:16]), 80'(8'h7C));
    check("t1_other", weights_o & ~80'hFF_0000, INIT & ~80'hFF_0000);
    check("t1_busy_low", 80'(busy_o), 80'(0));

    // Same frame with checksum 7E.
    pay[0] = 8'h7C;
    frame(8'h02, 8'h01, 8'h01, 0, 1'b0);
    check("t2_busy_low", 80'(busy_o), 80'(0));

    // Range overflow, then stray bytes that must be ignored.
    e0 = err_seen;
    frame(8'h09, 8'h02, 8'h00, 0, 1'b0);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    tick(3);
    check("t3_one_err", 80'(err_seen - e0), 80'(1));
    check("t3_idle", 80'(busy_o), 80'(0));

    // Full bank write held off by the network for 20 cycles.
    for (int k = 0; k < NW; k++) pay[k] = 8'($urandom);
    frame(8'h00, 8'h0A, 8'h00, 20, 1'b0);

    // Truncated frame left to time out.
    e0 = err_seen;
    begin
      exp_t e;
      e.is_done = 1'b0;
      e.w       = model_vec();
      sb.push_back(e);
    end
    send(8'hA5);
    send(8'h00);
    send(8'h03);
    send(8'h11);
    tick(250);
    check("t5_no_early_err", 80'(err_seen - e0), 80'(0));
    tick(50);
    check("t5_one_err", 80'(err_seen - e0), 80'(1));
    check("t5_idle", 80'(busy_o), 80'(0));

    // Reset in the middle of the data phase.
    send(8'hA5);
    send(8'h00);
    send(8'h04);
    send(8'h55);
    send(8'h66);
    #3;
    rst_i = 1'b1;
    #1;
    check("t6_weights_init", weights_o, INIT);
    check("t6_busy_low", 80'(busy_o), 80'(0));
    model_reset();
    sb.delete();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    tick(2);
    for (int k = 0; k < 4; k++) pay[k] = 8'($urandom);
    frame(8'h00, 8'h04, 8'h00, 0, 1'b1);

    // Randomised frames.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] a, l, flip;
      int         hold;
      a    = 8'($urandom_range(0, 11));
      l    = 8'($urandom_range(0, 10));
      flip = ($urandom_range(0, 4) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      for (int k = 0; k < 16; k++) pay[k] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        send(8'h3C);
        send(8'h00);
      end
      frame(a, l, flip, hold, 1'b1);
    end

    tick(5);
    check("scoreboard_drained", 80'(sb.size()), 80'(0));
    check("final_weights", weights_o, model_vec());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
